pong_game_ctrl: RTL

Game-control stage for the Pong display path, running on the 50 MHz `clk_50m` domain. It debounces the raw paddle buttons before they reach the graphics/animation unit. It consumes the per-frame refresh tick and the paddle-hit and ball-miss pulses produced by that unit. It sequences the game through new-game, play, new-ball and game-over states, maintains a two-digit BCD score and a life counter, and drives `gra_still` to freeze the ball when play is not active.

---
 rtl/pong_game_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game-control stage for the Pong display path.
// Synchronises and debounces the paddle buttons, sequences the game through
// new-game / play / new-ball / game-over, and keeps a BCD score and a life count.
module pong_game_ctrl #(
  parameter int unsigned DB_TICKS    = 500000,
  parameter int unsigned TIMER_TICKS = 120,
  parameter int unsigned LIVES       = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn_raw,
  input  logic       refr_tick,
  input  logic       hit,
  input  logic       miss,
  output logic [1:0] btn_db,
  output logic       gra_still,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [1:0] game_state
);

  localparam int unsigned     DBW        = $clog2(DB_TICKS);
  localparam logic [DBW-1:0]  DB_LAST    = DBW'(DB_TICKS - 1);
  localparam logic [7:0]      TMR_LOAD   = 8'(TIMER_TICKS);
  localparam logic [1:0]      LIVES_INIT = 2'(LIVES);

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'd0,
    ST_PLAY    = 2'd1,
    ST_NEWBALL = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  logic [1:0]     r_sync1;
  logic [1:0]     r_sync2;
  logic [DBW-1:0] r_db_cnt [2];
  logic [1:0]     r_btn_db;
  logic [1:0]     r_btn_db_d;
  state_t         r_state;
  logic           r_still;
  logic [7:0]     r_score;
  logic [1:0]     r_lives;
  logic [7:0]     r_timer;

  logic           w_press;
  logic           w_timer_done;
  logic [7:0]     w_score_inc;

  // Two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-bit debounce: accept a new level only after DB_TICKS consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
      r_btn_db    <= '0;
      r_btn_db_d  <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_btn_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_btn_db[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
      r_btn_db_d <= r_btn_db;
    end
  end

  assign w_press      = |(r_btn_db & ~r_btn_db_d);
  assign w_timer_done = (r_timer == '0);

  // Two-digit BCD increment with wrap from 99 to 00
  always_comb begin
    w_score_inc = r_score;
    if (r_score[3:0] == 4'd9) begin
      w_score_inc[3:0] = '0;
      w_score_inc[7:4] = (r_score[7:4] == 4'd9) ? 4'd0 : r_score[7:4] + 4'd1;
    end else begin
      w_score_inc[3:0] = r_score[3:0] + 4'd1;
    end
  end

  // Game sequencer with pause timer, score and life bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_NEWGAME;
      r_still <= 1'b1;
      r_score <= '0;
      r_lives <= LIVES_INIT;
      r_timer <= '0;
    end else begin
      case (r_state)
        ST_NEWGAME: begin
          if (w_press) begin
            r_state <= ST_PLAY;
            r_still <= 1'b0;
          end
        end
        ST_PLAY: begin
          // a miss takes priority over a simultaneous hit
          if (miss) begin
            r_timer <= TMR_LOAD;
            r_still <= 1'b1;
            if (r_lives > 2'd1) begin
              r_lives <= r_lives - 2'd1;
              r_state <= ST_NEWBALL;
            end else begin
              r_lives <= '0;
              r_state <= ST_OVER;
            end
          end else if (hit) begin
            r_score <= w_score_inc;
          end
        end
        ST_NEWBALL: begin
          if (w_timer_done && w_press) begin
            r_state <= ST_PLAY;
            r_still <= 1'b0;
          end else if (refr_tick && !w_timer_done) begin
            r_timer <= r_timer - 8'd1;
          end
        end
        ST_OVER: begin
          if (w_timer_done) begin
            r_state <= ST_NEWGAME;
            r_score <= '0;
            r_lives <= LIVES_INIT;
          end else if (refr_tick) begin
            r_timer <= r_timer - 8'd1;
          end
        end
        default: begin
          r_state <= ST_NEWGAME;
          r_still <= 1'b1;
        end
      endcase
    end
  end

  assign btn_db     = r_btn_db;
  assign gra_still  = r_still;
  assign score      = r_score;
  assign lives      = r_lives;
  assign game_state = r_state;

endmodule
